spi_serf: RTL and testbench
===========================

Name: spi_serf

Overview:
- SPI responder (serf) that pairs with the team's SPI_mnrch monarch.
- The serf receives 16-bit frames on MOSI and returns a preloaded 16-bit word on MISO, all in the system clk domain.
- SS_n, SCLK and MOSI are asynchronous to clk and are sampled through synchronizers; the serf never drives SCLK.
- Bus format matches the monarch: SCLK idles high, the serf drives MISO from the falling edge and samples MOSI on the rising edge, MSB first.

Parameters:
DATA_W, 16, frame length in bits and width of tx_data/rd_data

Ports:
clk  input  1  system clock; all logic on posedge clk
rst  input  1  synchronous active-high reset
SS_n  input  1  active-low select from monarch (async)
SCLK  input  1  serial clock from monarch, idles high (async)
MOSI  input  1  serial data from monarch (async)
MISO  output  1  serial data to monarch; driven only while raw SS_n=0, else 1'bz
wrt  input  1  load tx_data into shift register (accepted in IDLE only)
tx_data  input  DATA_W  word returned in next frame
clr_rdy  input  1  clears rdy
rdy  output  1  frame received; rd_data valid
rd_data  output  DATA_W  last complete received word
frame_err  output  1  one-cycle pulse: frame ended with bit count != DATA_W

Behaviour:
- Synchronizers: 3 flops each on SCLK and SS_n (stages ff1..ff3), 2 flops on MOSI. On rst, SCLK/SS_n flops load 1 and MOSI flops load 0.
- Edge detects:
  - sclk_rise = SCLK_ff2 & ~SCLK_ff3
  - ss_fall = ~SS_n_ff2 & SS_n_ff3
  - ss_rise = SS_n_ff2 & ~SS_n_ff3
- Sampling: MOSI_ff2 is sampled on sclk_rise, so SCLK and MOSI see equal sync delay. The bus therefore requires each SCLK phase >= 3 clk periods and MOSI stable >= 2 clk periods around the SCLK rise. The monarch provides 8.
- Shift register shft[DATA_W-1:0]; MISO = shft[DATA_W-1].
  - wrt in IDLE: shft <= tx_data.
  - sclk_rise in ACTIVE: shft <= {shft[DATA_W-2:0], MOSI_ff2}.
  - MISO updates after the detected rise, which is after the monarch samples and before the next falling edge.
- Bit counter bit_cnt, 5 bits (clog2(DATA_W)+1):
  - cleared on ss_fall;
  - incremented on sclk_rise in ACTIVE;
  - saturates at all-ones.
- State machine:
  - IDLE: wrt loads shft. ss_fall -> ACTIVE, clears bit_cnt and clears rdy.
  - ACTIVE: wrt is ignored (shft not disturbed). On ss_rise -> IDLE.
    - If bit_cnt == DATA_W: rd_data <= shft, rdy <= 1.
    - Otherwise: frame_err pulses for 1 cycle; rd_data and rdy are unchanged.
  - Illegal state encodings -> IDLE.
- Latency: rdy and rd_data update on the 3rd posedge clk after the first edge that samples SS_n high.
- Echo: without a new wrt, the next frame returns the previously received word (shft retains it).
- rdy:
  - set by a completed frame, cleared by clr_rdy or ss_fall;
  - set and clr_rdy in the same cycle -> rdy = 1 (set wins).
- Reset: rdy = 0, frame_err = 0, rd_data = 0, shft = 0, bit_cnt = 0, state = IDLE.
- Reset mid-frame (SS_n still low): the ss_fall detected after reset enters ACTIVE mid-frame. At SS_n rise, bit_cnt < DATA_W -> frame_err; no rdy.
- Extra SCLK rises beyond DATA_W: shifting continues, bit_cnt != DATA_W -> frame_err, no rdy.

Test Plan:
1. Reset: assert rst 2 cycles with SS_n=1 -> rdy=0, frame_err=0, rd_data=16'h0000, MISO=z.
2. Basic exchange against SPI_mnrch: serf wrt tx_data=16'hA5C3, then monarch wt_data=16'h1234 -> serf rdy=1 and rd_data=16'h1234; monarch done with rd_data=16'hA5C3.
3. Echo, back-to-back frames with no serf wrt:
   - second frame, monarch sends 16'hFFFF -> monarch receives 16'h1234, serf rd_data=16'hFFFF;
   - rdy clears at SS_n fall and re-asserts at the end of the frame.
4. Truncated frame: bench drives SS_n low, 8 SCLK pulses (8 clk per phase), SS_n high -> frame_err is a single 1-cycle pulse, rdy=0, rd_data unchanged.
5. Handshake corners:
   - clr_rdy in the same cycle rdy sets -> rdy=1; clr_rdy alone next cycle -> rdy=0;
   - wrt tx_data=16'h0F0F mid-frame -> ignored, monarch still receives the value loaded before the frame.
6. Reset mid-frame: rst pulse after 8 bits of a 16-bit monarch frame -> no rdy, frame_err pulse at SS_n rise; next full frame 16'hBEEF -> rdy=1, rd_data=16'hBEEF.

Source files
------------

// File: rtl/spi_serf.sv
// SPI responder (serf) for the SPI_mnrch monarch.
// Receives DATA_W-bit frames MSB first on MOSI (sampled on SCLK rise) and returns a
// preloaded word on MISO (changes after each detected rise). SCLK idles high.
// All bus inputs are asynchronous to clk and pass through synchronizers.
//
// Ports:
//   clk        system clock
//   rst        synchronous active-high reset
//   SS_n       active-low select from monarch (async)
//   SCLK       serial clock from monarch (async, idles high)
//   MOSI       serial data from monarch (async)
//   MISO       serial data to monarch, high-Z while raw SS_n is high
//   wrt        load tx_data into the shift register (IDLE only)
//   tx_data    word returned in the next frame
//   clr_rdy    clears rdy
//   rdy        a complete frame was received, rd_data valid
//   rd_data    last complete received word
//   frame_err  one-cycle pulse when a frame ends with a bit count other than DATA_W
module spi_serf #(
  parameter int unsigned DATA_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              SS_n,
  input  logic              SCLK,
  input  logic              MOSI,
  output logic              MISO,
  input  logic              wrt,
  input  logic [DATA_W-1:0] tx_data,
  input  logic              clr_rdy,
  output logic              rdy,
  output logic [DATA_W-1:0] rd_data,
  output logic              frame_err
);

  localparam int unsigned CntW = $clog2(DATA_W) + 1;

  typedef enum logic [1:0] {
    StIdle   = 2'b00,
    StActive = 2'b01
  } state_e;

  state_e              state_q, state_d;
  logic                sclk_ff1_q, sclk_ff2_q, sclk_ff3_q;
  logic                sclk_ff1_d, sclk_ff2_d, sclk_ff3_d;
  logic                ss_ff1_q, ss_ff2_q, ss_ff3_q;
  logic                ss_ff1_d, ss_ff2_d, ss_ff3_d;
  logic                mosi_ff1_q, mosi_ff2_q;
  logic                mosi_ff1_d, mosi_ff2_d;
  logic [DATA_W-1:0]   shft_q, shft_d;
  logic [CntW-1:0]     bit_cnt_q, bit_cnt_d;
  logic                rdy_q, rdy_d;
  logic [DATA_W-1:0]   rd_data_q, rd_data_d;
  logic                frame_err_q, frame_err_d;

  logic sclk_rise, ss_fall, ss_rise;
  logic rdy_set, rdy_clr_sel;

  // SCLK and MOSI both take their sampled value from stage 2, so they see equal delay.
  assign sclk_rise = sclk_ff2_q & ~sclk_ff3_q;
  assign ss_fall   = ~ss_ff2_q & ss_ff3_q;
  assign ss_rise   = ss_ff2_q & ~ss_ff3_q;

  always_comb begin
    sclk_ff1_d  = SCLK;
    sclk_ff2_d  = sclk_ff1_q;
    sclk_ff3_d  = sclk_ff2_q;
    ss_ff1_d    = SS_n;
    ss_ff2_d    = ss_ff1_q;
    ss_ff3_d    = ss_ff2_q;
    mosi_ff1_d  = MOSI;
    mosi_ff2_d  = mosi_ff1_q;

    state_d     = state_q;
    shft_d      = shft_q;
    bit_cnt_d   = bit_cnt_q;
    rd_data_d   = rd_data_q;
    frame_err_d = 1'b0;
    rdy_set     = 1'b0;
    rdy_clr_sel = 1'b0;

    if (ss_fall) begin
      bit_cnt_d = '0;
    end

    case (state_q)
      StIdle: begin
        if (wrt) begin
          shft_d = tx_data;
        end
        if (ss_fall) begin
          state_d     = StActive;
          rdy_clr_sel = 1'b1;
        end
      end
      StActive: begin
        if (sclk_rise) begin
          shft_d = {shft_q[DATA_W-2:0], mosi_ff2_q};
          if (bit_cnt_q != '1) begin
            bit_cnt_d = bit_cnt_q + 1'b1;
          end
        end
        if (ss_rise) begin
          state_d = StIdle;
          if (bit_cnt_q == CntW'(DATA_W)) begin
            rd_data_d = shft_q;
            rdy_set   = 1'b1;
          end else begin
            frame_err_d = 1'b1;
          end
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase

    // A completing frame wins over a simultaneous clr_rdy.
    rdy_d = rdy_q;
    if (clr_rdy || rdy_clr_sel) begin
      rdy_d = 1'b0;
    end
    if (rdy_set) begin
      rdy_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      sclk_ff1_q  <= 1'b1;
      sclk_ff2_q  <= 1'b1;
      sclk_ff3_q  <= 1'b1;
      ss_ff1_q    <= 1'b1;
      ss_ff2_q    <= 1'b1;
      ss_ff3_q    <= 1'b1;
      mosi_ff1_q  <= 1'b0;
      mosi_ff2_q  <= 1'b0;
      shft_q      <= '0;
      bit_cnt_q   <= '0;
      rdy_q       <= 1'b0;
      rd_data_q   <= '0;
      frame_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      sclk_ff1_q  <= sclk_ff1_d;
      sclk_ff2_q  <= sclk_ff2_d;
      sclk_ff3_q  <= sclk_ff3_d;
      ss_ff1_q    <= ss_ff1_d;
      ss_ff2_q    <= ss_ff2_d;
      ss_ff3_q    <= ss_ff3_d;
      mosi_ff1_q  <= mosi_ff1_d;
      mosi_ff2_q  <= mosi_ff2_d;
      shft_q      <= shft_d;
      bit_cnt_q   <= bit_cnt_d;
      rdy_q       <= rdy_d;
      rd_data_q   <= rd_data_d;
      frame_err_q <= frame_err_d;
    end
  end

  // Tri-state keyed on raw SS_n so the bus is released immediately on deselect.
  assign MISO      = SS_n ? 1'bz : shft_q[DATA_W-1];
  assign rdy       = rdy_q;
  assign rd_data   = rd_data_q;
  assign frame_err = frame_err_q;

endmodule

// File: tb/tb_spi_serf.sv
`timescale 1ns/1ps
module tb_spi_serf;

  logic        clk = 1'b0;
  logic        rst;
  logic        SS_n;
  logic        SCLK;
  logic        MOSI;
  wire         MISO;
  logic        wrt;
  logic [15:0] tx_data;
  logic        clr_rdy;
  logic        rdy;
  logic [15:0] rd_data;
  logic        frame_err;

  int checks = 0;
  int failures = 0;
  int err_cycles = 0;
  logic rdy_prev = 1'b0;
  logic [15:0] sb[$];

  always #5 clk = ~clk;

  spi_serf #(.DATA_W(16)) dut (
    .clk       (clk),
    .rst       (rst),
    .SS_n      (SS_n),
    .SCLK      (SCLK),
    .MOSI      (MOSI),
    .MISO      (MISO),
    .wrt       (wrt),
    .tx_data   (tx_data),
    .clr_rdy   (clr_rdy),
    .rdy       (rdy),
    .rd_data   (rd_data),
    .frame_err (frame_err)
  );

  // Scoreboard: each rising rdy must match the oldest expected word.
  always @(negedge clk) begin
    if (frame_err) err_cycles++;
    if (rdy && !rdy_prev) begin
      checks++;
      if (sb.size() == 0) begin
        failures++;
        $display("FAIL sb_unexpected_rdy: rd_data=%h with no expected word", rd_data);
      end else begin
        logic [15:0] e;
        e = sb.pop_front();
        if (rd_data !== e) begin
          failures++;
          $display("FAIL sb_rd_data: got %h expected %h", rd_data, e);
        end
      end
    end
    rdy_prev <= rdy;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic load(input logic [15:0] w);
    wrt = 1'b1;
    tx_data = w;
    @(posedge clk); #1;
    wrt = 1'b0;
  endtask

  // Monarch model: 8 clk per SCLK phase, MOSI changes on the fall, MISO sampled at the rise.
  task automatic spi_xfer(input logic [15:0] mosi_w, input int nbits, input bit mid_wrt,
                          input bit mid_rst, output logic [15:0] got, output logic rdy_mid);
    logic b;
    got = 16'h0;
    rdy_mid = 1'b0;
    SS_n = 1'b0;
    repeat (8) @(posedge clk); #1;
    for (int i = 0; i < nbits; i++) begin
      b = (i < 16) ? mosi_w[15-i] : 1'b0;
      if (mid_rst && i == 8) begin
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
      end
      SCLK = 1'b0;
      MOSI = b;
      if (mid_wrt && i == 8) begin
        wrt = 1'b1;
        tx_data = 16'h0F0F;
        @(posedge clk); #1;
        wrt = 1'b0;
        repeat (7) @(posedge clk);
      end else begin
        repeat (8) @(posedge clk);
      end
      #1;
      if (i == 4) rdy_mid = rdy;
      got = {got[14:0], MISO};
      SCLK = 1'b1;
      repeat (8) @(posedge clk); #1;
    end
    SS_n = 1'b1;
    MOSI = 1'b0;
  endtask

  task automatic post_check(input string tag, input logic [15:0] got, input logic [15:0] exp_miso,
                            input logic rdy_mid, input int err_before, input bit good,
                            input logic [15:0] exp_rd);
    repeat (6) @(posedge clk); #1;
    check({tag, "_miso"}, got, exp_miso);
    check({tag, "_rdy_mid"}, {15'h0, rdy_mid}, 16'h0);
    check({tag, "_rdy"}, {15'h0, rdy}, {15'h0, good});
    check({tag, "_err_cycles"}, 16'(err_cycles - err_before), good ? 16'h0 : 16'h1);
    check({tag, "_rd_data"}, rd_data, exp_rd);
  endtask

  typedef struct {
    bit          load;
    logic [15:0] tx;
    logic [15:0] mosi;
    int          nbits;
    logic [15:0] exp_miso;
    bit          exp_rdy;
  } vec_t;

  vec_t vecs[8];

  initial begin
    logic [15:0] got;
    logic        rdy_mid;
    logic [15:0] last_good;
    int          eb;

    vecs[0] = '{1'b1, 16'hA5C3, 16'h1234, 16, 16'hA5C3, 1'b1};
    vecs[1] = '{1'b0, 16'h0000, 16'hFFFF, 16, 16'h1234, 1'b1};  // echo
    vecs[2] = '{1'b0, 16'h0000, 16'hABCD, 8,  16'h00FF, 1'b0};  // truncated
    vecs[3] = '{1'b1, 16'h8001, 16'h7FFE, 16, 16'h8001, 1'b1};
    vecs[4] = '{1'b1, 16'h0000, 16'hFFFF, 16, 16'h0000, 1'b1};
    vecs[5] = '{1'b0, 16'h0000, 16'h5A5A, 17, 16'hFFFE, 1'b0};  // one extra rise
    vecs[6] = '{1'b1, 16'hFFFF, 16'h0000, 16, 16'hFFFF, 1'b1};
    vecs[7] = '{1'b1, 16'hC3A5, 16'h3C5A, 16, 16'hC3A5, 1'b1};

    rst = 1'b1; SS_n = 1'b1; SCLK = 1'b1; MOSI = 1'b0;
    wrt = 1'b0; tx_data = 16'h0; clr_rdy = 1'b0;
    repeat (2) @(posedge clk); #1;
    rst = 1'b0;
    check("reset_rdy", {15'h0, rdy}, 16'h0);
    check("reset_frame_err", {15'h0, frame_err}, 16'h0);
    check("reset_rd_data", rd_data, 16'h0000);
    checks++;
    if (MISO !== 1'bz) begin
      failures++;
      $display("FAIL reset_miso: got %b expected z", MISO);
    end
    repeat (4) @(posedge clk); #1;

    last_good = 16'h0000;
    for (int v = 0; v < 8; v++) begin
      if (vecs[v].load) load(vecs[v].tx);
      if (vecs[v].exp_rdy) sb.push_back(vecs[v].mosi);
      eb = err_cycles;
      spi_xfer(vecs[v].mosi, vecs[v].nbits, 1'b0, 1'b0, got, rdy_mid);
      if (vecs[v].exp_rdy) last_good = vecs[v].mosi;
      post_check($sformatf("vec%0d", v), got, vecs[v].exp_miso, rdy_mid, eb,
                 vecs[v].exp_rdy, last_good);
    end

    // Mid-frame wrt ignored; rdy set and clr_rdy in the same cycle.
    load(16'h3C3C);
    sb.push_back(16'h6996);
    eb = err_cycles;
    spi_xfer(16'h6996, 16, 1'b1, 1'b0, got, rdy_mid);
    @(posedge clk);
    @(posedge clk); #1;
    clr_rdy = 1'b1;
    @(posedge clk); #1;
    clr_rdy = 1'b0;
    check("set_wins_rdy", {15'h0, rdy}, 16'h1);
    check("hs_rd_data", rd_data, 16'h6996);
    check("hs_miso_ignores_wrt", got, 16'h3C3C);
    clr_rdy = 1'b1;
    @(posedge clk); #1;
    clr_rdy = 1'b0;
    check("clr_rdy_alone", {15'h0, rdy}, 16'h0);
    check("hs_err_cycles", 16'(err_cycles - eb), 16'h0);
    repeat (4) @(posedge clk); #1;

    // Reset after 8 bits of a frame: no rdy, one frame_err; rd_data returns to 0.
    eb = err_cycles;
    spi_xfer(16'h1357, 16, 1'b0, 1'b1, got, rdy_mid);
    post_check("midrst", got, 16'h6900, rdy_mid, eb, 1'b0, 16'h0000);

    sb.push_back(16'hBEEF);
    eb = err_cycles;
    spi_xfer(16'hBEEF, 16, 1'b0, 1'b0, got, rdy_mid);
    post_check("after_rst", got, 16'h0057, rdy_mid, eb, 1'b1, 16'hBEEF);

    repeat (4) @(posedge clk); #1;
    check("sb_drained", 16'(sb.size()), 16'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
